// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Purpose  : Configures and sequences a programmable serial pattern detector
//             and reports matches. A pattern/length/limit is accepted over a
//             valid/ready config handshake. Qualified serial bits are then
//             shifted through a history register. Hits are suppressed until
//             the history holds `len` bits. Each match is reported over a
//             single-entry valid/ready channel with a sticky overflow flag.
//             The block disarms after `limit` matches or on abort.
//  Ports    : clk, reset (async, active-high)
//             cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_limit - config
//             din_valid/din                                     - bit stream
//             abort                                             - disarm
//             match_valid/match_ready/match_pos                 - report
//             match_count, overflow, state                      - status
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int W     = 5,
    parameter int CNT_W = 8,
    parameter int POS_W = 16,
    parameter int LEN_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             din_valid,
    input  logic             din,
    input  logic             abort,
    output logic             match_valid,
    input  logic             match_ready,
    output logic [POS_W-1:0] match_pos,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(W);
    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [W-1:0]     r_pattern;
    logic [W-1:0]     r_mask;
    logic [CNT_W-1:0] r_limit;
    logic [W-1:0]     r_shift;
    logic [LEN_W-1:0] r_fill;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_count;
    logic             r_mvalid;
    logic [POS_W-1:0] r_mpos;
    logic             r_ovf;

    logic [LEN_W-1:0] w_cfg_len;
    logic [W-1:0]     w_cfg_mask;
    logic             w_accept;
    logic [W-1:0]     w_shift_next;
    logic [POS_W-1:0] w_pos_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_hit;
    logic             w_consume;
    logic             w_slot_free;
    logic             w_limit_hit;

    // Length clamp: 0 behaves as 1, anything above W behaves as W.
    assign w_cfg_len  = (cfg_len == '0)       ? c_LEN_ONE :
                        (cfg_len > c_LEN_MAX) ? c_LEN_MAX : cfg_len;
    // Ones in the w_cfg_len LSBs; a shift by W yields zero, so len==W gives all ones.
    assign w_cfg_mask = ~({W{1'b1}} << w_cfg_len);

    // abort wins over a coincident data bit.
    assign w_accept     = din_valid && !abort && (r_state == S_FILL || r_state == S_RUN);
    assign w_shift_next = {r_shift[W-2:0], din};
    assign w_pos_next   = (&r_pos) ? r_pos : r_pos + POS_W'(1);
    assign w_fill_next  = (r_fill == c_LEN_MAX) ? r_fill : r_fill + c_LEN_ONE;
    assign w_count_next = (&r_count) ? r_count : r_count + CNT_W'(1);
    assign w_hit        = w_accept && (w_fill_next >= r_len) &&
                          ((w_shift_next & r_mask) == r_pattern);
    assign w_consume    = r_mvalid && match_ready;
    assign w_slot_free  = !r_mvalid || w_consume;
    assign w_limit_hit  = (r_limit != '0) && (w_count_next == r_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_pattern <= '0;
            r_mask    <= '0;
            r_limit   <= '0;
            r_shift   <= '0;
            r_fill    <= '0;
            r_pos     <= '0;
            r_count   <= '0;
            r_mvalid  <= 1'b0;
            r_mpos    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            // Default: a consumed report empties the slot; a hit below may refill it.
            if (w_consume) begin
                r_mvalid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_len     <= w_cfg_len;
                        r_mask    <= w_cfg_mask;
                        r_pattern <= cfg_pattern & w_cfg_mask;
                        r_limit   <= cfg_limit;
                        r_shift   <= '0;
                        r_fill    <= '0;
                        r_pos     <= '0;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL, S_RUN: begin
                    if (abort) begin
                        r_mvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_accept) begin
                        r_shift <= w_shift_next;
                        r_pos   <= w_pos_next;
                        r_fill  <= w_fill_next;
                        if (r_state == S_FILL && w_fill_next == r_len) begin
                            r_state <= S_RUN;
                        end
                        if (w_hit) begin
                            r_count <= w_count_next;
                            if (w_slot_free) begin
                                r_mvalid <= 1'b1;
                                r_mpos   <= w_pos_next;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                            // Limit reached overrides the FILL->RUN step.
                            if (w_limit_hit) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // Leave only once the last report is gone or being taken.
                    if (abort || w_slot_free) begin
                        r_mvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = (r_state == S_IDLE);
    assign match_valid = r_mvalid;
    assign match_pos   = r_mpos;
    assign match_count = r_count;
    assign overflow    = r_ovf;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_ctrl
//  Purpose  : Directed self-checking bench for seq_detect_ctrl. Inputs change
//             1 time unit after a rising edge; outputs are sampled there too.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_pattern;
    logic [2:0]  cfg_len;
    logic [7:0]  cfg_limit;
    logic        din_valid;
    logic        din;
    logic        abort;
    logic        match_valid;
    logic        match_ready;
    logic [15:0] match_pos;
    logic [7:0]  match_count;
    logic        overflow;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    seq_detect_ctrl #(.W(5), .CNT_W(8), .POS_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_limit   (cfg_limit),
        .din_valid   (din_valid),
        .din         (din),
        .abort       (abort),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .match_pos   (match_pos),
        .match_count (match_count),
        .overflow    (overflow),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [4:0] pat, input logic [2:0] len, input logic [7:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_limit   = lim;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        din_valid = 1'b1;
        din       = b;
        step();
        din_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_limit = '0;
        din_valid = 1'b0; din = 1'b0; abort = 1'b0; match_ready = 1'b1;
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_mvalid", match_valid, 0);
        chk("rst_mpos", match_pos, 0);
        chk("rst_count", match_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        step();

        // Fill guard: pattern 00, len 2, shift history starts at zero.
        do_cfg(5'b00000, 3'd2, 8'd0);
        chk("fg_state_fill", state, 1);
        chk("fg_cfg_ready", cfg_ready, 0);
        send_bit(1'b0);
        chk("fg_bit1_nohit", match_valid, 0);
        chk("fg_bit1_state", state, 1);
        send_bit(1'b0);
        chk("fg_bit2_mvalid", match_valid, 1);
        chk("fg_bit2_mpos", match_pos, 2);
        chk("fg_bit2_count", match_count, 1);
        chk("fg_bit2_state_run", state, 2);
        // Config while armed is ignored.
        do_cfg(5'b11111, 3'd1, 8'd0);
        chk("fg_cfg_ignored", state, 2);
        do_abort();
        chk("fg_abort_state", state, 0);
        chk("fg_abort_cfg_ready", cfg_ready, 1);
        chk("fg_abort_mvalid", match_valid, 0);
        chk("fg_abort_count_kept", match_count, 1);
        chk("fg_abort_mpos_kept", match_pos, 2);

        // Pattern 10110, len 5.
        do_cfg(5'b10110, 3'd5, 8'd0);
        chk("p5_count_cleared", match_count, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("p5_no_early_hit", match_valid, 0);
        send_bit(1'b0);
        chk("p5_mvalid", match_valid, 1);
        chk("p5_mpos", match_pos, 5);
        chk("p5_count", match_count, 1);
        step();
        chk("p5_pulse_end", match_valid, 0);
        do_abort();

        // Pattern 101, len 3, overlapping matches.
        do_cfg(5'b00101, 3'd3, 8'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("ov_first_mpos", match_pos, 3);
        chk("ov_first_valid", match_valid, 1);
        send_bit(1'b0);
        chk("ov_consumed", match_valid, 0);
        send_bit(1'b1);
        chk("ov_second_mpos", match_pos, 5);
        chk("ov_second_count", match_count, 2);
        do_abort();

        // Back-to-back hits with ready high: no bubble, no overflow.
        do_cfg(5'b00001, 3'd1, 8'd0);
        send_bit(1'b1);
        chk("bb_first_mpos", match_pos, 1);
        send_bit(1'b1);
        chk("bb_second_valid", match_valid, 1);
        chk("bb_second_mpos", match_pos, 2);
        chk("bb_no_ovf", overflow, 0);
        do_abort();

        // Backpressure: second report dropped.
        match_ready = 1'b0;
        do_cfg(5'b00001, 3'd1, 8'd0);
        chk("bp_ovf_cleared", overflow, 0);
        send_bit(1'b1);
        chk("bp_first_mpos", match_pos, 1);
        send_bit(1'b1);
        chk("bp_held_mpos", match_pos, 1);
        chk("bp_held_valid", match_valid, 1);
        chk("bp_ovf", overflow, 1);
        chk("bp_count", match_count, 2);
        match_ready = 1'b1;
        step();
        chk("bp_drained", match_valid, 0);
        chk("bp_state_run", state, 2);
        do_abort();

        // Limit 2 with backpressure.
        match_ready = 1'b0;
        do_cfg(5'b00001, 3'd1, 8'd2);
        send_bit(1'b1);
        chk("lim_first_state", state, 2);
        send_bit(1'b1);
        chk("lim_done", state, 3);
        chk("lim_count", match_count, 2);
        send_bit(1'b1);
        chk("lim_ignored_count", match_count, 2);
        chk("lim_ignored_mpos", match_pos, 1);
        chk("lim_still_done", state, 3);
        match_ready = 1'b1;
        step();
        chk("lim_idle", state, 0);
        chk("lim_cfg_ready", cfg_ready, 1);
        chk("lim_mvalid", match_valid, 0);

        // len 0 clamps to 1: pattern 11110 masks down to 0.
        do_cfg(5'b11110, 3'd0, 8'd0);
        send_bit(1'b0);
        chk("clamp_hit", match_valid, 1);
        chk("clamp_mpos", match_pos, 1);
        do_abort();

        // Abort together with a bit in FILL; cfg+abort in IDLE accepted.
        abort = 1'b1;
        do_cfg(5'b00001, 3'd1, 8'd0);
        abort = 1'b0;
        chk("ab_cfg_with_abort", state, 1);
        abort = 1'b1;
        send_bit(1'b1);
        abort = 1'b0;
        chk("ab_state_idle", state, 0);
        chk("ab_bit_not_counted", match_count, 0);
        chk("ab_no_report", match_valid, 0);

        // Asynchronous reset while a report is pending in RUN.
        match_ready = 1'b0;
        do_cfg(5'b00001, 3'd1, 8'd0);
        send_bit(1'b1);
        chk("ar_pre_valid", match_valid, 1);
        chk("ar_pre_state", state, 2);
        reset = 1'b1;
        #1;
        chk("ar_state", state, 0);
        chk("ar_mvalid", match_valid, 0);
        chk("ar_mpos", match_pos, 0);
        chk("ar_count", match_count, 0);
        chk("ar_cfg_ready", cfg_ready, 1);
        step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Controller that configures, sequences and reports for a programmable serial pattern detector. It accepts a pattern, length and match limit over a valid/ready config handshake. It then runs the detector over a qualified bit stream, suppressing false hits until the shift history holds `len` bits. Matches are reported over a single-entry valid/ready report channel with a sticky overflow flag; the block disarms after a programmable number of matches or on abort.

## Interface
- `W`, 5, maximum pattern length in bits (≥2)
- `CNT_W`, 8, width of match counter and limit
- `POS_W`, 16, width of bit-position counter
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config accepted when high; equals (state==IDLE)
- `cfg_pattern`  in  W  pattern, last-received bit in bit 0
- `cfg_len`  in  $clog2(W+1)  pattern length; 0 clamps to 1, >W clamps to W
- `cfg_limit`  in  CNT_W  matches before auto-disarm; 0 = unlimited
- `din_valid`  in  1  qualifies `din`
- `din`  in  1  serial data bit
- `abort`  in  1  return to IDLE
- `match_valid`  out  1  report pending
- `match_ready`  in  1  report consumer ready
- `match_pos`  out  POS_W  1-based index of the bit completing the match
- `match_count`  out  CNT_W  matches since arm, saturating
- `overflow`  out  1  sticky: a report was dropped
- `state`  out  2  IDLE=0, FILL=1, RUN=2, DONE=3

## Operation
- IDLE: on `cfg_valid`, latch the clamped len. Latch pattern masked to its len LSBs. Latch limit. Clear the shift register, fill counter, pos, `match_count` and `overflow`. Go to FILL.
- Accepted bit: `din_valid` in FILL or RUN.
  - shift_next = {shift[W-2:0], din}.
  - pos++ (saturating).
  - fill++ (saturating at W).
- Hit condition: an accepted bit where fill_next ≥ len and (shift_next & mask) == pattern. Overlapping matches count.
- FILL→RUN when fill_next == len. A hit on that same bit is valid.
- On a hit:
  - `match_count`++, saturating at all-ones.
  - If `match_valid`==0, or `match_valid`&&`match_ready` this cycle: load `match_valid`=1 and `match_pos`=pos_next.
  - Otherwise drop the report and set `overflow`=1; the count still increments.
- Limit: if limit≠0 and match_count_next == limit, go to DONE. Bits in DONE are ignored, with no shift and no pos increment.
- DONE→IDLE on the cycle when `match_valid`==0, or when it is being consumed.
- Report consumption: `match_valid`&&`match_ready` clears `match_valid` next cycle, unless a new hit reloads it in the same cycle.
- `abort` in FILL/RUN/DONE: go to IDLE next cycle and clear `match_valid`.
  - `match_count`, `match_pos` and `overflow` are retained for readback.
  - `abort` beats `din_valid` in the same cycle; that bit is ignored.
- `abort` in IDLE: no effect. `cfg_valid` outside IDLE: ignored.
- `cfg_valid` and `abort` together in IDLE: config is accepted.

## Timing
- Reset values:
  - `state`=IDLE, so `cfg_ready`=1.
  - `match_valid`=0, `match_pos`=0, `match_count`=0, `overflow`=0.
  - Internal: shift register, fill counter and pos all 0.
- Config accepted at edge N: `state`=FILL from N+1. The first data bit can be accepted at N+1.
- Hit bit accepted at edge N: `match_valid`, `match_pos` and `match_count` update at N+1. DONE, if limit is reached, is also entered at N+1.
- Hit at N with `match_ready`=1 at N consuming the old report: the new report is visible at N+1 with no bubble.
- Abort asserted at edge N: `state`=IDLE at N+1 and `cfg_ready`=1 at N+1.
- Asynchronous reset mid-operation: all outputs take reset values immediately. Any pending report is lost.
- Saturation:
  - pos at 2^POS_W−1 holds.
  - `match_count` at 2^CNT_W−1 holds. The limit compare uses the saturated value.

## Test plan
- Pattern 5'b10110, len 5, limit 0; bits 1,0,1,1,0 with `match_ready`=1 → `match_valid` pulses one cycle after the 5th bit, with `match_pos`=5 and `match_count`=1.
- Pattern 3'b101, len 3; bits 1,0,1,0,1 → reports with `match_pos`=3 and 5; `match_count`=2 (overlap).
- Fill guard: pattern 2'b00, len 2, immediately after reset with the shift register at zero:
  - bit 0 → no hit;
  - second bit 0 → hit at `match_pos`=2.
- Backpressure: pattern 1'b1, len 1, `match_ready`=0; bits 1,1 → report holds `match_pos`=1, the second report is dropped, `overflow`=1 and `match_count`=2.
- Limit: pattern 1'b1, len 1, limit 2, `match_ready`=0; bits 1,1,1 →
  - DONE after the second hit;
  - third bit ignored, `match_count`=2;
  - raising `match_ready` → IDLE next cycle and `cfg_ready`=1.
- Abort and reset:
  - `abort` together with `din_valid` in FILL → IDLE next cycle; pos unchanged and the bit is not counted.
  - `reset` pulsed in RUN with `match_valid`=1 → all outputs are zero immediately and `state`=IDLE.
